// File: rtl/fifo_word_unpacker.sv
// Pops 32-bit words from a synchronous FIFO and replays them as a byte stream on a
// valid/ready interface, flagging the last byte of each word and counting finished words.
module fifo_word_unpacker #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                xfer;
  logic                last_xfer;
  logic [IDX_W-1:0]    idx_nx;

  function automatic logic [BYTE_W-1:0] head_byte(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1 -: BYTE_W];
    else                return w[BYTE_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_byte(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w << BYTE_W;
    else                return w >> BYTE_W;
  endfunction

  assign xfer      = valid_q && m_ready;
  assign last_xfer = xfer && last_q;
  assign idx_nx    = idx_q + 1'b1;

  // The next word is requested in the same cycle the current one finishes, so
  // back-to-back words only lose the single WAIT cycle.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_SEND) && last_xfer));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d = fifo_data;
        idx_d   = '0;
        valid_d = 1'b1;
        last_d  = (NBYTES == 1);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          shreg_d = drop_byte(shreg_q);
          idx_d   = idx_nx;
          last_d  = (idx_nx == LAST_IDX);
          if (last_q) begin
            cnt_d   = cnt_q + 16'd1;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = fifo_empty ? S_IDLE : S_WAIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign m_valid  = valid_q;
  assign m_data   = head_byte(shreg_q);
  assign m_last   = last_q;
  assign busy     = (state_q != S_IDLE);
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: behavioural FIFO feeding an MSB-first and an
// LSB-first instance, table-driven single words plus hand-written multi-cycle sequences.
module tb_fifo_word_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fifo_empty, fifo_rd_en, m_valid, m_last, m_ready, busy;
  logic [31:0] fifo_data;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;

  logic        fifo_empty_l, fifo_rd_en_l, m_valid_l, m_last_l, m_ready_l, busy_l;
  logic [31:0] fifo_data_l;
  logic [7:0]  m_data_l;
  logic [15:0] word_cnt_l;

  fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .word_cnt(word_cnt)
  );

  fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_l), .fifo_rd_en(fifo_rd_en_l),
    .fifo_data(fifo_data_l), .m_valid(m_valid_l), .m_data(m_data_l), .m_last(m_last_l),
    .m_ready(m_ready_l), .busy(busy_l), .word_cnt(word_cnt_l)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] fq[$];
  logic [7:0]  got_b[$];
  logic        got_l[$];
  int          got_t[$];
  logic [7:0]  got_bl[$];
  logic        got_ll[$];
  int          cyc_n = 0;
  int          rd_cnt = 0;
  int          rd_on_last = 0;

  logic        s_rd, s_valid, s_last, s_busy, s_rd_l;
  logic [7:0]  s_data;
  logic [15:0] s_cnt, s_cnt_l;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;
  vec_t tbl[3];

  logic [7:0] exp_b[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, then let the FIFO model pop #1 after posedge.
  task automatic cyc();
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy;
    s_cnt   = word_cnt;
    s_rd_l  = fifo_rd_en_l;
    s_cnt_l = word_cnt_l;
    if (m_valid && m_ready) begin
      got_b.push_back(m_data);
      got_l.push_back(m_last);
      got_t.push_back(cyc_n);
      if (fifo_rd_en && m_last) rd_on_last++;
    end
    if (m_valid_l && m_ready_l) begin
      got_bl.push_back(m_data_l);
      got_ll.push_back(m_last_l);
    end
    if (s_rd) rd_cnt++;
    chk("rd_en_while_empty", 32'(s_rd & fifo_empty), 32'd0);
    chk("rd_en_l_while_empty", 32'(s_rd_l & fifo_empty_l), 32'd0);
    cyc_n++;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0) begin
      fifo_data  = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    if (s_rd_l) fifo_empty_l = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clr();
    got_b.delete();
    got_l.delete();
    got_t.delete();
    got_bl.delete();
    got_ll.delete();
    rd_cnt = 0;
    rd_on_last = 0;
  endtask

  task automatic take4(input int base, output logic [31:0] bytes, output logic [3:0] lasts);
    bytes = '0;
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_b.size()) begin
        bytes = {bytes[23:0], got_b[base+i]};
        lasts = {lasts[2:0], got_l[base+i]};
      end else begin
        bytes = {bytes[23:0], 8'h00};
        lasts = {lasts[2:0], 1'b0};
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bytes;
    logic [3:0]  lasts;
    logic [15:0] lmask;
    int          bad;

    tbl[0] = '{32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
    tbl[1] = '{32'hFF00A55A, 8'hFF, 8'h00, 8'hA5, 8'h5A};
    tbl[2] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    exp_b  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
               8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};

    rst = 1'b1; m_ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
    fifo_empty_l = 1'b1; fifo_data_l = 32'h11223344; m_ready_l = 1'b1;
    @(posedge clk);
    #1;
    run(2);
    chk("rst_m_valid", 32'(s_valid), 32'd0);
    chk("rst_m_data", 32'(s_data), 32'd0);
    chk("rst_m_last", 32'(s_last), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_word_cnt", 32'(s_cnt), 32'd0);

    // A word waiting in the FIFO must not be popped while reset is held.
    push(32'hDEADBEEF);
    cyc();
    chk("rd_en_forced_low_in_rst", 32'(s_rd), 32'd0);
    chk("no_pop_in_rst", 32'(fq.size()), 32'd1);

    // Startup latency: rd_en in cycle N, WAIT in N+1, first byte in N+2.
    rst = 1'b0;
    clr();
    cyc();
    chk("start_rd_en", 32'(s_rd), 32'd1);
    chk("start_idle_valid", 32'(s_valid), 32'd0);
    cyc();
    chk("wait_rd_en", 32'(s_rd), 32'd0);
    chk("wait_valid", 32'(s_valid), 32'd0);
    chk("wait_busy", 32'(s_busy), 32'd1);
    cyc();
    chk("first_valid", 32'(s_valid), 32'd1);
    chk("first_data", 32'(s_data), 32'hDE);
    run(6);
    take4(0, bytes, lasts);
    chk("single_bytes", bytes, 32'hDEADBEEF);
    chk("single_lasts", 32'(lasts), 32'h1);
    chk("single_count", 32'(got_b.size()), 32'd4);
    chk("single_rd_pulses", 32'(rd_cnt), 32'd1);
    chk("single_word_cnt", 32'(s_cnt), 32'd1);
    chk("single_idle", 32'(s_busy), 32'd0);

    for (int i = 0; i < 3; i++) begin
      clr();
      push(tbl[i].word);
      run(10);
      take4(0, bytes, lasts);
      chk("tbl_bytes", bytes, {tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3});
      chk("tbl_lasts", 32'(lasts), 32'h1);
      chk("tbl_rd_pulses", 32'(rd_cnt), 32'd1);
      chk("tbl_word_cnt", 32'(s_cnt), 32'(2 + i));
      chk("tbl_idle", 32'(s_busy), 32'd0);
    end

    clr();
    fifo_empty_l = 1'b0;
    run(8);
    bytes = '0;
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < got_bl.size()) begin
        bytes = {bytes[23:0], got_bl[i]};
        lasts = {lasts[2:0], got_ll[i]};
      end
    end
    chk("lsb_count", 32'(got_bl.size()), 32'd4);
    chk("lsb_bytes", bytes, 32'h44332211);
    chk("lsb_lasts", 32'(lasts), 32'h1);
    chk("lsb_word_cnt", 32'(s_cnt_l), 32'd1);

    // Backpressure on the second byte for three cycles.
    clr();
    push(32'hA5A55A5A);
    for (int k = 0; k < 10 && got_b.size() == 0; k++) cyc();
    chk("bp_first_byte", 32'(got_b.size()), 32'd1);
    m_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("bp_hold_valid", 32'(s_valid), 32'd1);
      chk("bp_hold_data", 32'(s_data), 32'hA5);
      chk("bp_hold_last", 32'(s_last), 32'd0);
    end
    m_ready = 1'b1;
    run(8);
    take4(0, bytes, lasts);
    chk("bp_count", 32'(got_b.size()), 32'd4);
    chk("bp_bytes", bytes, 32'hA5A55A5A);
    chk("bp_lasts", 32'(lasts), 32'h1);
    chk("bp_word_cnt", 32'(s_cnt), 32'd5);

    clr();
    push(32'h01234567);
    push(32'h89ABCDEF);
    push(32'h0F1E2D3C);
    push(32'h4B5A6978);
    run(30);
    chk("b2b_count", 32'(got_b.size()), 32'd16);
    lmask = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < got_b.size()) begin
        chk("b2b_byte", 32'(got_b[i]), 32'(exp_b[i]));
        lmask = {lmask[14:0], got_l[i]};
      end
    end
    chk("b2b_lasts", 32'(lmask), 32'h1111);
    chk("b2b_rd_pulses", 32'(rd_cnt), 32'd4);
    chk("b2b_rd_on_last", 32'(rd_on_last), 32'd3);
    if (got_t.size() == 16) begin
      chk("b2b_span", 32'(got_t[15] - got_t[0]), 32'd18);
      chk("b2b_gap", 32'(got_t[4] - got_t[3]), 32'd2);
    end
    chk("b2b_word_cnt", 32'(s_cnt), 32'd9);
    chk("b2b_idle", 32'(s_busy), 32'd0);

    clr();
    bad = 0;
    repeat (10) begin
      cyc();
      if (s_valid || s_rd || s_busy) bad++;
    end
    chk("empty_quiet", 32'(bad), 32'd0);

    // Reset after the second byte discards the rest of the word.
    clr();
    push(32'hCAFEF00D);
    for (int k = 0; k < 10 && got_b.size() < 2; k++) cyc();
    chk("mid_two_bytes", 32'(got_b.size()), 32'd2);
    rst = 1'b1;
    m_ready = 1'b0;
    cyc();
    chk("mid_rst_rd_en", 32'(s_rd), 32'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    cyc();
    chk("mid_post_valid", 32'(s_valid), 32'd0);
    chk("mid_post_data", 32'(s_data), 32'd0);
    chk("mid_post_last", 32'(s_last), 32'd0);
    chk("mid_post_busy", 32'(s_busy), 32'd0);
    chk("mid_post_cnt", 32'(s_cnt), 32'd0);
    run(6);
    chk("mid_no_more_bytes", 32'(got_b.size()), 32'd2);
    take4(0, bytes, lasts);
    chk("mid_sent_bytes", bytes[31:16], 32'hCAFE);

    clr();
    push(32'h13579BDF);
    run(10);
    take4(0, bytes, lasts);
    chk("after_rst_bytes", bytes, 32'h13579BDF);
    chk("after_rst_lasts", 32'(lasts), 32'h1);
    chk("after_rst_cnt", 32'(s_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Downstream consumer of the 32-bit synchronous FIFO. It pops words via the FIFO's read-enable/empty interface and emits each word as a sequence of bytes on a valid/ready stream, MSB byte first by default, marking the last byte of every word. It sits between the FIFO read port and any byte-wide sink (serializer, UART TX, bus packer), and counts completed words.

## Interface
Parameters:
- DATA_W, 32, FIFO word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, output byte width; NBYTES = DATA_W/BYTE_W (4 at defaults).
- MSB_FIRST, 1, 1 = most-significant byte first, 0 = least-significant byte first.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable (drives FIFO r_en).
- fifo_data  in  DATA_W  FIFO data_out.
- m_valid  out  1  output byte valid.
- m_data  out  BYTE_W  output byte.
- m_last  out  1  high with the final byte of a word.
- m_ready  in  1  sink ready.
- busy  out  1  high in any state other than IDLE.
- word_cnt  out  16  count of words fully transmitted; wraps.

## Operation
- FIFO contract: the FIFO samples fifo_rd_en on a clock edge E and presents the popped word on fifo_data from E until its next pop.
- FSM states: IDLE, WAIT, SEND.
- IDLE: fifo_rd_en = !fifo_empty (combinational). If !fifo_empty, go to WAIT at the next edge.
- WAIT: fifo_rd_en = 0. At the next edge, load fifo_data into the shift register, set byte index to 0, and go to SEND.
- SEND: m_valid = 1. m_data = current byte: bits [DATA_W-1 -: BYTE_W] shifted left when MSB_FIRST, bits [BYTE_W-1:0] shifted right otherwise. m_last = (index == NBYTES-1).
- Handshake in SEND: a transfer occurs when m_valid & m_ready. On a transfer, advance the index and shift. With no transfer, m_data and m_last hold stable.
- Last-byte transfer in SEND: word_cnt increments by 1 (0xFFFF wraps to 0x0000). Also fifo_rd_en = !fifo_empty in that same cycle. Next state is WAIT if !fifo_empty, else IDLE.
- fifo_rd_en is never asserted when fifo_empty = 1. It is never asserted in WAIT, in SEND before the last-byte transfer, or in any cycle where rst = 1.
- m_valid never deasserts in SEND without a last-byte transfer.

## Timing
- Reset values: state IDLE, m_valid 0, m_data 0, m_last 0, fifo_rd_en 0, busy 0, word_cnt 0, shift register 0, index 0.
- Reset mid-operation: the partial word is discarded and not counted. Outputs take their reset values at the edge where rst is sampled high, and fifo_rd_en is forced to 0 combinationally while rst = 1.
- Startup latency: fifo_empty falls in IDLE at cycle N, so fifo_rd_en is high in cycle N. WAIT occupies cycle N+1, and the first m_valid appears in cycle N+2.
- Word duration with m_ready tied high: NBYTES cycles in SEND plus 1 WAIT cycle. Back-to-back words give 4 bytes per 5 cycles at defaults, with exactly one m_valid-low cycle between words.
- busy is high in WAIT and SEND and low only in IDLE. word_cnt updates on the edge ending the last-byte transfer.
- m_data is a registered shift-register output, with no combinational path from m_ready to m_data. fifo_rd_en is combinational from state, fifo_empty, m_ready and rst.

## Test plan
- Single word: push 0xDEADBEEF, m_ready = 1. Expect exactly one fifo_rd_en pulse, then bytes DE, AD, BE, EF on consecutive cycles, m_last only on EF, word_cnt = 1, then IDLE with busy = 0.
- MSB_FIRST = 0: push 0x11223344. Expect 44, 33, 22, 11 with m_last on 11.
- Backpressure: push 0xA5A55A5A and hold m_ready low for 3 cycles on the second byte. Expect m_data = A5 and m_valid = 1 held stable with no index advance, then the remaining bytes after m_ready rises. Total bytes = 4.
- Back-to-back: push 4 random words, m_ready = 1. Expect fifo_rd_en to coincide with each m_last transfer while the FIFO is not empty, 16 bytes in order, one-cycle gaps between words, word_cnt = 4, and no rd_en once empty.
- Empty and reset: with the FIFO empty, expect fifo_rd_en = 0 and m_valid = 0 indefinitely. Push 0xCAFEF00D and assert rst for 1 cycle after the second byte. Expect all outputs at reset values, word_cnt = 0, the remaining bytes not sent, and the next FIFO word unpacked normally afterwards.
